// File: rtl/bit_divider_8_if.sv
// Operand/result bundle for bit_divider_8.
// master: the side that issues Start and operands; slave: the divider.
interface bit_divider_8_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             DivByZero;
    logic             Ovf;

    modport master (
        output Start, Dividend, Divisor,
        input  Busy, Done, Quotient, Remainder, DivByZero, Ovf
    );

    modport slave (
        input  Start, Dividend, Divisor,
        output Busy, Done, Quotient, Remainder, DivByZero, Ovf
    );
endinterface

// File: rtl/bit_divider_8.sv
// Sequential restoring (shift-subtract) divider, WIDTH iterations per result.
// Define BIT_DIVIDER_SIGNED_EN for two's-complement operands with sign
// correction and overflow flag; otherwise operands are unsigned and Ovf is 0.
//
// state | meaning
// IDLE  | waiting for Start; operands captured on the Start edge
// LOAD  | divide-by-zero check, form magnitudes, clear partial remainder
// ITER  | one shift/trial-subtract step per edge, WIDTH steps
// FIX   | sign correction, register Quotient/Remainder
// DONE  | Done high, results held until Start returns low
module bit_divider_8 #(
    parameter int WIDTH = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    bit_divider_8_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;         // raw captured dividend
    logic [WIDTH-1:0] dvs_q, dvs_d;         // raw captured divisor
    logic [WIDTH-1:0] mag_dvs_q, mag_dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;         // dividend bits shift out, quotient bits shift in
    logic [WIDTH:0]   rem_q, rem_d;         // partial remainder
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;

    // Next-state, datapath and result computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        mag_dvs_d   = mag_dvs_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        // Partial remainder never exceeds the divisor, so dropping its MSB
        // on the shift loses nothing.
        rem_shift = (WIDTH+1)'({rem_q, quo_q[WIDTH-1]});
        trial     = rem_shift - {1'b0, mag_dvs_q};

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    dvd_d   = bus.Dividend;
                    dvs_d   = bus.Divisor;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (dvs_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                    dbz_d       = 1'b1;
                    ovf_d       = 1'b0;
                    state_d     = S_DONE;
                end else begin
`ifdef BIT_DIVIDER_SIGNED_EN
                    quo_d     = dvd_q[WIDTH-1] ? -dvd_q : dvd_q;
                    mag_dvs_d = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
`else
                    quo_d     = dvd_q;
                    mag_dvs_d = dvs_q;
`endif
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (trial[WIDTH]) begin
                    rem_d = rem_shift;
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = trial;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
`ifdef BIT_DIVIDER_SIGNED_EN
                // Quotient truncates toward zero; remainder follows dividend sign.
                quotient_d  = (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]) ? -quo_q : quo_q;
                remainder_d = dvd_q[WIDTH-1] ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                ovf_d       = (dvd_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&dvs_q);
`else
                quotient_d  = quo_q;
                remainder_d = rem_q[WIDTH-1:0];
                ovf_d       = 1'b0;
`endif
                dbz_d   = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!bus.Start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_ITER) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            mag_dvs_q   <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            mag_dvs_q   <= mag_dvs_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Quotient  = quotient_q;
    assign bus.Remainder = remainder_q;
    assign bus.DivByZero = dbz_q;
    assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_bit_divider_8.sv
// Self-checking bench for bit_divider_8 against an arithmetic reference.
module tb_bit_divider_8;
    localparam int WIDTH = 8;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;

    bit_divider_8_if #(.WIDTH(WIDTH)) bus ();

    bit_divider_8 #(.WIDTH(WIDTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] held_q = '0;
    logic [7:0] held_r = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division on the operand interpretation.
    function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic z, output logic o);
        int sa, sb, qi, ri;
        if (b == 8'd0) begin
            q = 8'hFF; r = a; z = 1'b1; o = 1'b0;
        end else begin
`ifdef BIT_DIVIDER_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            qi = sa / sb;
            ri = sa % sb;
            q = 8'(qi);
            r = 8'(ri);
            z = 1'b0;
            o = (qi > 127) || (qi < -128);
`ifndef BIT_DIVIDER_SIGNED_EN
            o = 1'b0;
`endif
        end
    endfunction

    // mode 0: plain; 1: scramble operands mid-run; 2: toggle Start while busy;
    // 3: hold Start through DONE for 20 cycles.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int mode);
        logic [7:0] eq, er;
        logic ez, eo;
        int lat;
        ref_div(a, b, eq, er, ez, eo);
        @(negedge Clk);
        bus.Dividend = a;
        bus.Divisor  = b;
        bus.Start    = 1'b1;
        Reset        = 1'b1;
        lat = -1;
        do begin
            @(negedge Clk);
            lat++;
            if (!bus.Done) begin
                if (lat >= 1) check_val("busy", 32'(bus.Busy), 1);
                if (lat == 5) check_val("held_quot", 32'(bus.Quotient), 32'(held_q));
                if (mode == 1 && lat == 3) begin
                    bus.Dividend = 8'($urandom);
                    bus.Divisor  = 8'($urandom);
                end
                if (mode == 2) bus.Start = (lat == 4);
            end
        end while (!bus.Done && lat < 40);
        check_val("latency", lat, (b == 8'd0) ? 1 : WIDTH + 2);
        check_val("quot", 32'(bus.Quotient), 32'(eq));
        check_val("rem", 32'(bus.Remainder), 32'(er));
        check_val("dbz", 32'(bus.DivByZero), 32'(ez));
        check_val("ovf", 32'(bus.Ovf), 32'(eo));
        check_val("busy_done", 32'(bus.Busy), 0);
        held_q = eq;
        held_r = er;
        if (mode == 3) begin
            repeat (20) begin
                @(negedge Clk);
                check_val("hold_done", 32'(bus.Done), 1);
                check_val("hold_busy", 32'(bus.Busy), 0);
                check_val("hold_quot", 32'(bus.Quotient), 32'(eq));
            end
        end
        bus.Start = 1'b0;
        @(negedge Clk);
        check_val("idle_done", 32'(bus.Done), 0);
        check_val("idle_rem", 32'(bus.Remainder), 32'(held_r));
    endtask

    initial begin
        logic [7:0] a, b;
        bus.Start    = 1'b0;
        bus.Dividend = '0;
        bus.Divisor  = '0;
        repeat (2) @(negedge Clk);
        check_val("rst_busy", 32'(bus.Busy), 0);
        check_val("rst_done", 32'(bus.Done), 0);
        check_val("rst_quot", 32'(bus.Quotient), 0);
        check_val("rst_rem", 32'(bus.Remainder), 0);
        check_val("rst_dbz", 32'(bus.DivByZero), 0);
        check_val("rst_ovf", 32'(bus.Ovf), 0);
        Reset = 1'b1;

        run_op(8'd100, 8'd7, 0);
        check_val("u100_7_q", 32'(bus.Quotient), 32'h0E);
        check_val("u100_7_r", 32'(bus.Remainder), 32'h02);

        run_op(8'h55, 8'h00, 0);
        check_val("dz_q", 32'(bus.Quotient), 32'hFF);
        check_val("dz_r", 32'(bus.Remainder), 32'h55);
        check_val("dz_flag", 32'(bus.DivByZero), 1);
        run_op(8'h10, 8'h04, 0);
        check_val("dz_clr_q", 32'(bus.Quotient), 32'h04);
        check_val("dz_clr_r", 32'(bus.Remainder), 32'h00);
        check_val("dz_clr_flag", 32'(bus.DivByZero), 0);

        run_op(8'hF9, 8'h02, 0);
`ifdef BIT_DIVIDER_SIGNED_EN
        check_val("s_f9_q", 32'(bus.Quotient), 32'hFD);
        check_val("s_f9_r", 32'(bus.Remainder), 32'hFF);
`else
        check_val("u_f9_q", 32'(bus.Quotient), 32'h7C);
        check_val("u_f9_r", 32'(bus.Remainder), 32'h01);
`endif

        run_op(8'h80, 8'hFF, 0);
`ifdef BIT_DIVIDER_SIGNED_EN
        check_val("ovf_q", 32'(bus.Quotient), 32'h80);
        check_val("ovf_r", 32'(bus.Remainder), 32'h00);
        check_val("ovf_flag", 32'(bus.Ovf), 1);
`endif

        // Asynchronous reset in the middle of an operation.
        @(negedge Clk);
        bus.Dividend = 8'd200;
        bus.Divisor  = 8'd3;
        bus.Start    = 1'b1;
        @(posedge Clk);
        repeat (5) @(posedge Clk);
        #1 Reset = 1'b0;
        #1;
        check_val("mid_rst_busy", 32'(bus.Busy), 0);
        check_val("mid_rst_done", 32'(bus.Done), 0);
        check_val("mid_rst_quot", 32'(bus.Quotient), 0);
        check_val("mid_rst_rem", 32'(bus.Remainder), 0);
        held_q = '0;
        held_r = '0;
        run_op(8'd200, 8'd3, 0);
`ifndef BIT_DIVIDER_SIGNED_EN
        check_val("after_rst_q", 32'(bus.Quotient), 32'h42);
        check_val("after_rst_r", 32'(bus.Remainder), 32'h02);
`endif

        run_op(8'd77, 8'd5, 3);
        run_op(8'd231, 8'd9, 1);
        run_op(8'd143, 8'd11, 2);

        for (int i = 0; i < 150; i++) begin
            a = 8'($urandom);
            case ($urandom_range(0, 5))
                0: b = 8'h00;
                1: b = 8'h01;
                2: b = 8'hFF;
                3: a = 8'h80;
                default: b = 8'($urandom);
            endcase
            if (i % 6 == 3) b = 8'($urandom);
            run_op(a, b, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/bit_divider_8.md
Name: bit_divider_8

Overview:
- Sequential shift-subtract (restoring) divider; the inverse of the shift-add multiplier datapath.
- Takes a dividend and a divisor and produces a quotient and a remainder after WIDTH iteration cycles.
- Sits beside the multiplier in the lab top level and uses the same synchronized Start/operand style of control.
- Outputs are held until the next operation, so they can drive the hex displays directly.

Parameters:
- WIDTH, 8: operand, quotient and remainder width in bits.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  synchronized run request; level-sensitive, must return low before the next operation.
- Dividend  input  WIDTH  dividend; sampled only on the Start edge taken in IDLE.
- Divisor  input  WIDTH  divisor; sampled with Dividend.
- Busy  output  1  high in LOAD, ITER and FIX.
- Done  output  1  high while in DONE.
- Quotient  output  WIDTH  result quotient, registered.
- Remainder  output  WIDTH  result remainder, registered.
- DivByZero  output  1  latched flag for the last operation.
- Ovf  output  1  latched signed-overflow flag for the last operation.

Behaviour:
- Reset low, at any time including mid-operation:
  - state goes to IDLE and the iteration count clears;
  - Busy, Done, DivByZero and Ovf go to 0;
  - Quotient and Remainder go to 0.
- States and transitions:
  - IDLE: Start=1 → LOAD. Dividend and Divisor are captured into internal registers on this edge.
  - LOAD:
    - If divisor == 0 → DONE, with Quotient = all ones, Remainder = captured dividend, DivByZero=1.
    - Otherwise form operand magnitudes, clear the partial remainder (WIDTH+1 bits), set count=0 → ITER.
  - ITER, one edge per iteration:
    - shift {partial remainder, quotient} left by 1, with the next dividend bit entering;
    - trial = partial remainder − divisor;
    - if trial is non-negative, keep trial and set the quotient LSB to 1; otherwise restore and set it to 0;
    - count increments; the edge that performs iteration WIDTH−1 goes → FIX.
  - FIX: apply sign correction (see Optional Feature) and register Quotient/Remainder → DONE.
  - DONE: Done=1 and outputs are held. Start=0 → IDLE. Start held high stays in DONE, so there is no auto-restart.
- Latency: with the Start edge in IDLE as edge 0, Done is first high after edge WIDTH+2 (edge 10 for WIDTH=8). Divide-by-zero: Done is high after edge 1.
- Start changes while Busy are ignored. Operand inputs are don't-care after capture; changing them mid-operation does not alter the result.
- Quotient, Remainder, DivByZero and Ovf change only on the edge entering DONE (or on reset). They hold through DONE and IDLE until the next result.
- All arithmetic is unsigned on WIDTH-bit magnitudes, with a WIDTH+1-bit partial remainder so there is no overflow in the trial subtract.

Optional Feature:
- Macro: BIT_DIVIDER_SIGNED_EN.
- Defined (two's-complement operands):
  - LOAD takes absolute values; a magnitude of −2^(WIDTH−1) is representable as unsigned.
  - FIX negates the quotient when the operand signs differ, and negates the remainder when the dividend is negative. The quotient truncates toward zero and the remainder takes the dividend's sign.
  - −2^(WIDTH−1) / −1 gives Quotient=0x80 (wrapped), Remainder=0, Ovf=1.
  - Divide-by-zero behaves as in unsigned mode (Quotient all ones, Remainder = raw dividend).
- Undefined: operands are unsigned, FIX performs no correction (still one cycle, so latency is identical), and Ovf is tied 0.

Test Plan:
- Unsigned: Dividend=100, Divisor=7, Start high then low after Done → Quotient=0x0E, Remainder=0x02, Done first high after edge 10, Busy high edges 1–9, DivByZero=0.
- Divide by zero: Dividend=0x55, Divisor=0 → Done after edge 1, Quotient=0xFF, Remainder=0x55, DivByZero=1. A following 0x10/0x04 clears the flag: Quotient=0x04, Remainder=0.
- Sign handling: 0xF9 / 0x02.
  - With BIT_DIVIDER_SIGNED_EN: Quotient=0xFD (−3), Remainder=0xFF (−1).
  - Without it: Quotient=0x7C, Remainder=0x01.
- Signed overflow (macro on): 0x80 / 0xFF → Quotient=0x80, Remainder=0x00, Ovf=1.
- Reset mid-operation: start 200/3, pull Reset low at edge 5 → Busy=0, Done=0, Quotient=0, Remainder=0 immediately, without waiting for a clock edge. Release Reset with Start high → a new operation runs and gives Quotient=0x42, Remainder=0x02.
- Control rules:
  - Keep Start high through DONE for 20 cycles → exactly one operation, Done stays high.
  - Change Dividend and Divisor during ITER → result still matches the captured operands.
  - Pulse Start during Busy → ignored.
